lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: MEM_BYTES, default 512, byte size of the attached memory; power of two, minimum 4.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: req_valid_i  in  1  core request valid.
REQ-005 Port: req_ready_o  out  1  LSU can accept a request.
REQ-006 Port: req_we_i  in  1  1 = store, 0 = load.
REQ-007 Port: req_funct3_i  in  3  RV32I width code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-008 Port: req_addr_i  in  32  byte address.
REQ-009 Port: req_wdata_i  in  32  store data, right-aligned.
REQ-010 Port: rsp_valid_o  out  1  response valid.
REQ-011 Port: rsp_ready_i  in  1  core accepts the response.
REQ-012 Port: rsp_rdata_o  out  32  load result, extended; 0 for stores.
REQ-013 Port: rsp_err_o  out  1  request rejected, no memory access made.
REQ-014 Port: ctrl_mem_ren_o  out  1  memory read enable.
REQ-015 Port: ctrl_mem_wren_o  out  1  memory write enable; 4 bytes written at mem_addr_o.
REQ-016 Port: mem_addr_o  out  32  word-aligned byte address, (req_addr_i & ~3) mod MEM_BYTES.
REQ-017 Port: mem_wdata_o  out  32  full word to write.
REQ-018 Port: mem_rdata_i  in  32  memory read word; valid in the same cycle as ctrl_mem_ren_o.

Function
REQ-019 FSM states IDLE, READ, WRITE, RESP; req_ready_o = 1 only in IDLE.
REQ-020 IDLE: on req_valid_i, capture we/funct3/addr/wdata; load or sub-word store -> READ; SW -> WRITE; rejected request -> RESP with err = 1.
REQ-021 READ: ctrl_mem_ren_o = 1 for exactly one cycle; capture mem_rdata_i at the cycle end; load -> RESP; SB/SH -> WRITE.
REQ-022 WRITE: ctrl_mem_wren_o = 1 for exactly one cycle; SW writes wdata unchanged; SB/SH merge the low byte/half into the captured word at lane addr[1:0]/addr[1]; -> RESP.
REQ-023 Load extraction: select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-024 RESP: rsp_valid_o held with stable rdata/err until rsp_valid_o & rsp_ready_i, then -> IDLE; a new request is accepted no earlier than the following cycle.
REQ-025 Latency from accept edge to rsp_valid_o: load 2 cycles, SW 2, SB/SH 3, error 1.
REQ-026 ren and wren never both asserted; both 0 outside READ and WRITE; mem_addr_o/mem_wdata_o are held from captured values.
REQ-027 Address arithmetic wraps modulo MEM_BYTES; no address is out of range.

Reset
REQ-028 While rst = 1: state IDLE, all outputs 0 except req_ready_o = 0; the captured registers are cleared.
REQ-029 rst mid-operation aborts immediately; a pending READ/WRITE is dropped, no response is produced, and req_ready_o = 1 on the first clock after release.

Configuration
REQ-030 Macro LSU_ERR_CHECK_EN defined: reject misaligned requests (H/HU/SH with addr[0] set; W/SW with addr[1:0] != 0) and illegal funct3 (3, 6, 7; 4/5 on stores) via rsp_err_o = 1.
REQ-031 Macro undefined: rsp_err_o tied 0; low address bits ignored for lane selection beyond the access width (H uses addr[1], W uses none); illegal funct3 treated as W.

Verification
REQ-032 Reset, then SW addr 0x10 data 0xDEADBEEF -> wren in cycle 1 with mem_addr 0x10; rsp in cycle 2, err 0.
REQ-033 LB addr 0x13 after REQ-032 -> rsp_rdata 0xFFFFFFDE; LBU -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD.
REQ-034 SB addr 0x11 data 0x55 -> READ then WRITE with mem_wdata 0xDEAD55EF; rsp 3 cycles after accept.
REQ-035 Hold rsp_ready_i = 0 for 5 cycles -> rsp_valid_o and data stable, req_ready_o = 0, no memory enables.
REQ-036 With LSU_ERR_CHECK_EN: LW addr 0x02 -> rsp_err 1 after 1 cycle, no ren/wren; without the macro, LW 0x02 reads word 0x00.
REQ-037 Assert rst during the READ state of an SB -> no wren, no response, req_ready_o = 1 after release.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: RV32I B/H/W/BU/HU accesses on a word-wide memory, sub-word stores by read-modify-write; LSU_ERR_CHECK_EN enables request rejection.
// Latency accept->rsp_valid_o: load 2, SW 2, SB/SH 3, rejected request 1 cycle.
// Backpressure: one request in flight; req_ready_o only in IDLE, response held until rsp_ready_i.
`timescale 1ns/1ps
module lsu #(
    parameter int MEM_BYTES = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        ctrl_mem_ren_o,
    output logic        ctrl_mem_wren_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);
    localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1) & ~32'd3;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t      state, state_nxt;
    size_t       req_size, size_q;
    logic        req_uns, req_err, accept;
    logic [1:0]  req_off, off_q;
    logic        we_q, uns_q, err_q;
    logic [31:0] addr_q, wdata_q, word_q;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val, merged;

    // Stores only know B/H/W; funct3 4/5 on a store falls through to a word access.
    always_comb begin
        req_size = SZ_W;
        req_uns  = 1'b0;
        case (req_funct3_i)
            3'd0: req_size = SZ_B;
            3'd1: req_size = SZ_H;
            3'd4: begin
                req_size = req_we_i ? SZ_W : SZ_B;
                req_uns  = !req_we_i;
            end
            3'd5: begin
                req_size = req_we_i ? SZ_W : SZ_H;
                req_uns  = !req_we_i;
            end
            default: req_size = SZ_W;
        endcase
    end

    always_comb begin
        case (req_size)
            SZ_B:    req_off = req_addr_i[1:0];
            SZ_H:    req_off = {req_addr_i[1], 1'b0};
            default: req_off = 2'b00;
        endcase
    end

`ifdef LSU_ERR_CHECK_EN
    always_comb begin
        req_err = 1'b0;
        case (req_funct3_i)
            3'd3, 3'd6, 3'd7: req_err = 1'b1;
            3'd4, 3'd5:       req_err = req_we_i;
            default:          req_err = 1'b0;
        endcase
        if (req_size == SZ_H && req_addr_i[0])
            req_err = 1'b1;
        if (req_size == SZ_W && req_addr_i[1:0] != 2'b00)
            req_err = 1'b1;
    end
`else
    assign req_err = 1'b0;
`endif

    assign accept = req_valid_i && req_ready_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_err)
                        state_nxt = RESP;
                    else if (req_we_i && req_size == SZ_W)
                        state_nxt = WRITE;
                    else
                        state_nxt = READ;
                end
            end
            READ:    state_nxt = we_q ? WRITE : RESP;
            WRITE:   state_nxt = RESP;
            RESP:    if (rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o     = 1'b0;
        rsp_valid_o     = 1'b0;
        ctrl_mem_ren_o  = 1'b0;
        ctrl_mem_wren_o = 1'b0;
        case (state)
            IDLE:    req_ready_o     = !rst;
            READ:    ctrl_mem_ren_o  = 1'b1;
            WRITE:   ctrl_mem_wren_o = 1'b1;
            RESP:    rsp_valid_o     = 1'b1;
            default: req_ready_o     = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_B;
            off_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we_i;
                uns_q   <= req_uns;
                err_q   <= req_err;
                size_q  <= req_size;
                off_q   <= req_off;
                addr_q  <= req_addr_i & ADDR_MASK;
                wdata_q <= req_wdata_i;
            end
            if (state == READ)
                word_q <= mem_rdata_i;
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    lane_b = word_q[7:0];
            2'd1:    lane_b = word_q[15:8];
            2'd2:    lane_b = word_q[23:16];
            default: lane_b = word_q[31:24];
        endcase
        lane_h = off_q[1] ? word_q[31:16] : word_q[15:0];
        case (size_q)
            SZ_B:    load_val = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_H:    load_val = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_val = word_q;
        endcase
    end

    // Sub-word stores patch the word fetched in READ; word stores bypass it.
    always_comb begin
        merged = word_q;
        case (size_q)
            SZ_B: begin
                case (off_q)
                    2'd0:    merged[7:0]   = wdata_q[7:0];
                    2'd1:    merged[15:8]  = wdata_q[7:0];
                    2'd2:    merged[23:16] = wdata_q[7:0];
                    default: merged[31:24] = wdata_q[7:0];
                endcase
            end
            SZ_H: begin
                if (off_q[1])
                    merged[31:16] = wdata_q[15:0];
                else
                    merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = merged;
    assign rsp_err_o   = rsp_valid_o & err_q;
    assign rsp_rdata_o = (rsp_valid_o && !we_q && !err_q) ? load_val : 32'd0;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a word memory behind the mem port and a scoreboard of expected responses.
`timescale 1ns/1ps
module tb_lsu;
    localparam int MEM_BYTES = 512;
    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [31:0] AMASK = 32'(MEM_BYTES - 1) & ~32'd3;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [4:0]  lat;
        logic [4:0]  ren_at;
        logic [4:0]  wren_at;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [4:0]  waits;
    } rsp_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] erd;
        logic        err;
        logic [4:0]  lat;
        logic [31:0] ewd;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        ren, wren;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:MEM_BYTES/4-1];
    logic        mem_clr;
    int          tests = 0;
    int          fails = 0;
    int          both_cnt = 0;
    int          wren_cnt = 0;
    int          rsp_cnt = 0;
    int          send_waits = 0;
    rsp_t        sb [$];

    lsu #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .ctrl_mem_ren_o(ren), .ctrl_mem_wren_o(wren),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[AW-1:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < MEM_BYTES/4; i++) mem[i] <= '0;
        end else if (wren) begin
            mem[mem_addr[AW-1:2]] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (ren && wren) both_cnt <= both_cnt + 1;
        if (wren) wren_cnt <= wren_cnt + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    function automatic string fmt(input rsp_t r);
        return $sformatf("rd=%h err=%b lat=%0d ren@%0d wren@%0d waddr=%h wdata=%h waits=%0d",
                         r.rdata, r.err, r.lat, r.ren_at, r.wren_at, r.waddr, r.wdata, r.waits);
    endfunction

    function automatic op_t op(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] erd, input logic err, input int lat, input logic [31:0] ewd);
        op_t o;
        o.we = we; o.f3 = f3; o.addr = addr; o.wd = wd;
        o.erd = erd; o.err = err; o.lat = 5'(lat); o.ewd = ewd;
        return o;
    endfunction

    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
        logic [31:0] s;
        case (f3)
            3'd0: begin s = w >> (8 * a);    return {{24{s[7]}}, s[7:0]}; end
            3'd4: begin s = w >> (8 * a);    return {24'd0, s[7:0]}; end
            3'd1: begin s = w >> (16 * a[1]); return {{16{s[15]}}, s[15:0]}; end
            3'd5: begin s = w >> (16 * a[1]); return {16'd0, s[15:0]}; end
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_model(input logic [31:0] old, input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] d);
        logic [31:0] m;
        int sh;
        case (f3)
            3'd0:    begin sh = 8 * a;     m = 32'h0000_00FF << sh; end
            3'd1:    begin sh = 16 * a[1]; m = 32'h0000_FFFF << sh; end
            default: begin sh = 0;         m = 32'hFFFF_FFFF; end
        endcase
        return (old & ~m) | ((d << sh) & m);
    endfunction

    // Drives one request, waits (bounded) for acceptance and records what the response should look like.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] erd, input logic eerr, input int elat, input logic [31:0] ewd,
                        input bit push);
        rsp_t e;
        int   w;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL send_accept_timeout req_ready=%b after %0d cycles, required 1", req_ready, w);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        send_waits = w;
        e = '0;
        e.rdata = erd; e.err = eerr; e.lat = 5'(elat);
        if (!eerr) begin
            if (!we) e.ren_at = 5'd1;
            else if (elat == 2) e.wren_at = 5'd1;
            else begin e.ren_at = 5'd1; e.wren_at = 5'd2; end
            if (we) begin e.waddr = addr & AMASK; e.wdata = ewd; end
        end
        if (push) sb.push_back(e);
    endtask

    task automatic recv(output rsp_t o, output bit ok);
        o = '0; ok = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (ren && o.ren_at == 0) o.ren_at = 5'(k);
            if (wren && o.wren_at == 0) begin
                o.wren_at = 5'(k); o.waddr = mem_addr; o.wdata = mem_wdata;
            end
            if (rsp_valid) begin
                o.lat = 5'(k); o.rdata = rsp_rdata; o.err = rsp_err; ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        o.waits = 5'(send_waits);
    endtask

    task automatic ack;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({req_ready, rsp_valid, rsp_err, ren, wren} !== 5'b0 || rsp_rdata !== 32'd0 ||
            mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs got rdy=%b vld=%b err=%b ren=%b wren=%b rd=%h addr=%h wd=%h, required all 0",
                     req_ready, rsp_valid, rsp_err, ren, wren, rsp_rdata, mem_addr, mem_wdata);
        end
        req_valid = 1'b0; rsp_ready = 1'b0;
        mem_clr = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release got rdy=%b vld=%b, required rdy=1 vld=0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_sw;
        rsp_t o, e;
        bit   ok;
        send(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, 32'hDEAD_BEEF, 1'b1);
        recv(o, ok);
        ack();
        e = sb.pop_front();
        tests++;
        if (!ok || o !== e) begin
            fails++;
            $display("FAIL sw got %s ok=%b, required %s", fmt(o), ok, fmt(e));
        end
        tests++;
        if (mem[4] !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL sw_mem got %h, required deadbeef", mem[4]);
        end
    endtask

    task automatic test_loads;
        op_t  t [$];
        rsp_t o, e;
        bit   ok;
        t.push_back(op(1'b0, 3'd0, 32'h13, 0, 32'hFFFF_FFDE, 1'b0, 2, 0));
        t.push_back(op(1'b0, 3'd4, 32'h13, 0, 32'h0000_00DE, 1'b0, 2, 0));
        t.push_back(op(1'b0, 3'd1, 32'h12, 0, 32'hFFFF_DEAD, 1'b0, 2, 0));
        t.push_back(op(1'b0, 3'd5, 32'h12, 0, 32'h0000_DEAD, 1'b0, 2, 0));
        t.push_back(op(1'b0, 3'd2, 32'h10, 0, 32'hDEAD_BEEF, 1'b0, 2, 0));
        t.push_back(op(1'b0, 3'd0, 32'h11, 0, 32'hFFFF_FFBE, 1'b0, 2, 0));
        t.push_back(op(1'b0, 3'd4, 32'h10, 0, 32'h0000_00EF, 1'b0, 2, 0));
        t.push_back(op(1'b0, 3'd1, 32'h10, 0, 32'hFFFF_BEEF, 1'b0, 2, 0));
        foreach (t[i]) begin
            send(t[i].we, t[i].f3, t[i].addr, t[i].wd, t[i].erd, t[i].err, int'(t[i].lat), t[i].ewd, 1'b1);
            recv(o, ok);
            ack();
            e = sb.pop_front();
            tests++;
            if (!ok || o !== e) begin
                fails++;
                $display("FAIL load[%0d] got %s ok=%b, required %s", i, fmt(o), ok, fmt(e));
            end
        end
    endtask

    task automatic test_sub_store;
        op_t  t [$];
        rsp_t o, e;
        bit   ok;
        t.push_back(op(1'b1, 3'd0, 32'h11,        32'h55,        0,            1'b0, 3, 32'hDEAD_55EF));
        t.push_back(op(1'b1, 3'd1, 32'h16,        32'h1234_ABCD, 0,            1'b0, 3, 32'hABCD_0000));
        t.push_back(op(1'b0, 3'd2, 32'h14,        0,             32'hABCD_0000, 1'b0, 2, 0));
        t.push_back(op(1'b1, 3'd0, 32'h211,       32'h77,        0,            1'b0, 3, 32'hDEAD_77EF));
        t.push_back(op(1'b1, 3'd2, 32'hFFFF_FFFC, 32'h1357_2468, 0,            1'b0, 2, 32'h1357_2468));
        t.push_back(op(1'b0, 3'd2, 32'h1FC,       0,             32'h1357_2468, 1'b0, 2, 0));
        foreach (t[i]) begin
            send(t[i].we, t[i].f3, t[i].addr, t[i].wd, t[i].erd, t[i].err, int'(t[i].lat), t[i].ewd, 1'b1);
            recv(o, ok);
            ack();
            e = sb.pop_front();
            tests++;
            if (!ok || o !== e) begin
                fails++;
                $display("FAIL substore[%0d] got %s ok=%b, required %s", i, fmt(o), ok, fmt(e));
            end
        end
    endtask

    task automatic test_backpressure;
        rsp_t o, e;
        bit   ok;
        send(1'b0, 3'd2, 32'h10, 0, 32'hDEAD_77EF, 1'b0, 2, 0, 1'b1);
        recv(o, ok);
        e = sb.pop_front();
        tests++;
        if (!ok || o !== e) begin
            fails++;
            $display("FAIL bp_first got %s ok=%b, required %s", fmt(o), ok, fmt(e));
        end
        // A competing store is offered while the response is stalled; it must not be taken.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'd0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            tests++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_77EF || rsp_err !== 1'b0 ||
                req_ready !== 1'b0 || ren !== 1'b0 || wren !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d] got vld=%b rd=%h err=%b rdy=%b ren=%b wren=%b, required 1 dead77ef 0 0 0 0",
                         c, rsp_valid, rsp_rdata, rsp_err, req_ready, ren, wren);
            end
        end
        req_valid = 1'b0;
        ack();
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem[4] !== 32'hDEAD_77EF) begin
            fails++;
            $display("FAIL bp_release got vld=%b rdy=%b mem=%h, required 0 1 dead77ef", rsp_valid, req_ready, mem[4]);
        end
    endtask

    task automatic test_misaligned;
        op_t  t [$];
        rsp_t o, e;
        bit   ok;
`ifdef LSU_ERR_CHECK_EN
        t.push_back(op(1'b0, 3'd2, 32'h02, 0,     0, 1'b1, 1, 0));
        t.push_back(op(1'b1, 3'd1, 32'h11, 32'h1, 0, 1'b1, 1, 0));
        t.push_back(op(1'b0, 3'd5, 32'h13, 0,     0, 1'b1, 1, 0));
        t.push_back(op(1'b0, 3'd3, 32'h00, 0,     0, 1'b1, 1, 0));
        t.push_back(op(1'b1, 3'd4, 32'h10, 32'h1, 0, 1'b1, 1, 0));
        t.push_back(op(1'b1, 3'd2, 32'h12, 32'h1, 0, 1'b1, 1, 0));
        t.push_back(op(1'b0, 3'd2, 32'h10, 0,     32'hDEAD_77EF, 1'b0, 2, 0));
`else
        t.push_back(op(1'b1, 3'd2, 32'h00, 32'hCAFE_F00D, 0,             1'b0, 2, 32'hCAFE_F00D));
        t.push_back(op(1'b0, 3'd2, 32'h02, 0,             32'hCAFE_F00D, 1'b0, 2, 0));
        t.push_back(op(1'b0, 3'd1, 32'h03, 0,             32'hFFFF_CAFE, 1'b0, 2, 0));
        t.push_back(op(1'b0, 3'd5, 32'h01, 0,             32'h0000_F00D, 1'b0, 2, 0));
        t.push_back(op(1'b0, 3'd3, 32'h01, 0,             32'hCAFE_F00D, 1'b0, 2, 0));
        t.push_back(op(1'b1, 3'd5, 32'h05, 32'h1122_3344, 0,             1'b0, 2, 32'h1122_3344));
        t.push_back(op(1'b0, 3'd2, 32'h04, 0,             32'h1122_3344, 1'b0, 2, 0));
`endif
        foreach (t[i]) begin
            send(t[i].we, t[i].f3, t[i].addr, t[i].wd, t[i].erd, t[i].err, int'(t[i].lat), t[i].ewd, 1'b1);
            recv(o, ok);
            ack();
            e = sb.pop_front();
            tests++;
            if (!ok || o !== e) begin
                fails++;
                $display("FAIL misalign[%0d] got %s ok=%b, required %s", i, fmt(o), ok, fmt(e));
            end
        end
    endtask

    task automatic test_reset_mid;
        int w0, r0;
        send(1'b1, 3'd0, 32'h11, 32'h99, 0, 1'b0, 3, 0, 1'b0);
        #2;
        tests++;
        if (ren !== 1'b1) begin
            fails++;
            $display("FAIL rm_in_read got ren=%b, required 1", ren);
        end
        w0 = wren_cnt; r0 = rsp_cnt;
        rst = 1'b1;
        #1;
        tests++;
        if ({ren, wren, req_ready, rsp_valid} !== 4'b0) begin
            fails++;
            $display("FAIL rm_abort got ren=%b wren=%b rdy=%b vld=%b, required all 0", ren, wren, req_ready, rsp_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL rm_ready got %b, required 1", req_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (wren_cnt != w0 || rsp_cnt != r0 || mem[4] !== 32'hDEAD_77EF) begin
            fails++;
            $display("FAIL rm_quiet got wrens=%0d rsps=%0d mem=%h, required 0 0 dead77ef",
                     wren_cnt - w0, rsp_cnt - r0, mem[4]);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] refm [0:31];
        rsp_t        o, e;
        bit          ok;
        logic        we;
        logic [2:0]  f3;
        logic [1:0]  b;
        logic [31:0] addr, d, nw;
        int          idx;
        for (int i = 0; i < 32; i++) refm[i] = '0;
        for (int n = 0; n < 24; n++) begin
            we  = 1'($urandom_range(0, 1));
            idx = int'($urandom_range(16, 31));
            b   = 2'($urandom_range(0, 3));
            d   = $urandom;
            if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            if (f3 == 3'd1 || f3 == 3'd5) b[0] = 1'b0;
            if (f3 == 3'd2) b = 2'b00;
            addr = (32'($urandom_range(0, 7)) << 9) | 32'(idx * 4) | 32'(b);
            if (we) begin
                nw = st_model(refm[idx], f3, b, d);
                refm[idx] = nw;
                send(1'b1, f3, addr, d, 32'd0, 1'b0, (f3 == 3'd2) ? 2 : 3, nw, 1'b1);
            end else begin
                send(1'b0, f3, addr, 32'd0, ld_model(refm[idx], f3, b), 1'b0, 2, 32'd0, 1'b1);
            end
            recv(o, ok);
            ack();
            e = sb.pop_front();
            tests++;
            if (!ok || o !== e) begin
                fails++;
                $display("FAIL b2b[%0d] we=%b f3=%0d addr=%h got %s ok=%b, required %s",
                         n, we, f3, addr, fmt(o), ok, fmt(e));
            end
        end
    endtask

    initial begin
        rst = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        rsp_ready = 1'b0;
        test_reset();
        test_sw();
        test_loads();
        test_sub_store();
        test_backpressure();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        tests++;
        if (both_cnt != 0 || sb.size() != 0) begin
            fails++;
            $display("FAIL final ren_wren_overlap=%0d pending=%0d, required 0 0", both_cnt, sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
